// File: rtl/maxnet_wta.sv
// maxnet_wta: four-neuron MaxNet winner-take-all engine with a start/done handshake.
// Activations come from parameters; lateral inhibition runs until one neuron survives.
module maxnet_wta #(
    parameter logic [31:0] INIT0    = 32'h0000_E666,
    parameter logic [31:0] INIT1    = 32'h0000_4CCC,
    parameter logic [31:0] INIT2    = 32'h0000_8000,
    parameter logic [31:0] INIT3    = 32'h0000_B333,
    parameter logic [31:0] EPS      = 32'h0000_3333,
    parameter int          MAX_ITER = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        done,
    output logic [31:0] result
);

    localparam int CW = (MAX_ITER > 1) ? $clog2(MAX_ITER) : 1;
    localparam logic [CW-1:0]      CNT_LAST = CW'(MAX_ITER - 1);
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]      CNT_ZERO = CW'(0);
    localparam logic signed [31:0] EPS_S    = EPS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_r;
    logic               start_d_r;
    logic               done_r;
    logic [31:0]        result_r;
    logic [CW-1:0]      cnt_r;
    logic signed [31:0] a_r    [4];
    logic [31:0]        orig_r [4];

    logic               trig_s;
    logic signed [33:0] sum_s;
    logic signed [33:0] diff_s [4];
    logic signed [31:0] inh_s  [4];
    logic signed [31:0] n_s    [4];
    logic signed [31:0] relu_s [4];
    logic [3:0]         nz_s;
    logic [2:0]         nz_cnt_s;
    logic               term_s;
    logic [31:0]        win_s;

    assign done   = done_r;
    assign result = result_r;

    // Rising-edge detect on start.
    always_comb begin
        trig_s = start & ~start_d_r;
    end

    // One inhibition step for all neurons; the shift floors toward minus infinity.
    always_comb begin
        sum_s = 34'(a_r[0]) + 34'(a_r[1]) + 34'(a_r[2]) + 34'(a_r[3]);
        for (int i = 0; i < 4; i++) begin
            diff_s[i] = sum_s - 34'(a_r[i]);
            inh_s[i]  = 32'((64'(EPS_S) * 64'(diff_s[i])) >>> 16);
            n_s[i]    = a_r[i] - inh_s[i];
            if (n_s[i][31]) begin
                relu_s[i] = 32'sd0;
            end else begin
                relu_s[i] = n_s[i];
            end
            nz_s[i] = (relu_s[i] != 32'sd0);
        end
    end

    // Termination: at most one survivor, or the iteration cap is reached.
    always_comb begin
        nz_cnt_s = {2'b00, nz_s[0]} + {2'b00, nz_s[1]} + {2'b00, nz_s[2]} + {2'b00, nz_s[3]};
        if ((nz_cnt_s <= 3'd1) || (cnt_r == CNT_LAST)) begin
            term_s = 1'b1;
        end else begin
            term_s = 1'b0;
        end
    end

    // Winner is the lowest index still non-zero; an all-zero field reports 0.
    always_comb begin
        if (nz_s[0]) begin
            win_s = orig_r[0];
        end else if (nz_s[1]) begin
            win_s = orig_r[1];
        end else if (nz_s[2]) begin
            win_s = orig_r[2];
        end else if (nz_s[3]) begin
            win_s = orig_r[3];
        end else begin
            win_s = 32'h0000_0000;
        end
    end

    // Control FSM with activation, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            start_d_r <= 1'b0;
            done_r    <= 1'b0;
            result_r  <= 32'h0000_0000;
            cnt_r     <= CNT_ZERO;
            for (int i = 0; i < 4; i++) begin
                a_r[i]    <= 32'sd0;
                orig_r[i] <= 32'h0000_0000;
            end
        end else begin
            start_d_r <= start;
            case (state_r)
                IDLE: begin
                    if (trig_s) begin
                        state_r <= LOAD;
                    end
                end
                LOAD: begin
                    a_r[0]    <= INIT0;
                    a_r[1]    <= INIT1;
                    a_r[2]    <= INIT2;
                    a_r[3]    <= INIT3;
                    orig_r[0] <= INIT0;
                    orig_r[1] <= INIT1;
                    orig_r[2] <= INIT2;
                    orig_r[3] <= INIT3;
                    cnt_r     <= CNT_ZERO;
                    state_r   <= ITER;
                end
                ITER: begin
                    for (int i = 0; i < 4; i++) begin
                        a_r[i] <= relu_s[i];
                    end
                    cnt_r <= cnt_r + CNT_ONE;
                    if (term_s) begin
                        state_r  <= DONE;
                        done_r   <= 1'b1;
                        result_r <= win_s;
                    end
                end
                DONE: begin
                    if (trig_s) begin
                        done_r  <= 1'b0;
                        state_r <= LOAD;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maxnet_wta.sv
// Bench for maxnet_wta: random handshake timing against an arithmetic MaxNet model,
// with a default-parameter instance plus four instances covering tie, single, cap and zero cases.
module tb_maxnet_wta;

    localparam logic [31:0] D_I0  = 32'h0000_E666;
    localparam logic [31:0] D_I1  = 32'h0000_4CCC;
    localparam logic [31:0] D_I2  = 32'h0000_8000;
    localparam logic [31:0] D_I3  = 32'h0000_B333;
    localparam logic [31:0] D_EPS = 32'h0000_3333;
    localparam logic [31:0] ONE   = 32'h0001_0000;
    localparam logic [31:0] TWO   = 32'h0002_0000;
    localparam logic [31:0] ZERO  = 32'h0000_0000;
    localparam int          BUDGET = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start2;
    logic        done;
    logic [31:0] result;
    logic [3:0]  done_aux;
    logic [31:0] res_aux [4];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    maxnet_wta u_def (
        .clk(clk), .rst(rst), .start(start), .done(done), .result(result)
    );

    // Exact tie: the floored inhibition never drives a positive value to zero,
    // so this run ends on the iteration cap.
    maxnet_wta #(.INIT0(ONE), .INIT1(ONE), .INIT2(ONE), .INIT3(ONE)) u_tie (
        .clk(clk), .rst(rst), .start(start2), .done(done_aux[0]), .result(res_aux[0])
    );

    maxnet_wta #(.INIT0(ZERO), .INIT1(ZERO), .INIT2(TWO), .INIT3(ZERO)) u_one (
        .clk(clk), .rst(rst), .start(start2), .done(done_aux[1]), .result(res_aux[1])
    );

    maxnet_wta #(.MAX_ITER(2)) u_cap (
        .clk(clk), .rst(rst), .start(start2), .done(done_aux[2]), .result(res_aux[2])
    );

    maxnet_wta #(.INIT0(ZERO), .INIT1(ZERO), .INIT2(ZERO), .INIT3(ZERO)) u_zero (
        .clk(clk), .rst(rst), .start(start2), .done(done_aux[3]), .result(res_aux[3])
    );

    // MaxNet run computed directly from the update rule on real integers.
    function automatic void model(input logic [31:0] i0, input logic [31:0] i1,
                                  input logic [31:0] i2, input logic [31:0] i3,
                                  input logic [31:0] eps, input int max_iter,
                                  output logic [31:0] res, output int n);
        logic [31:0] orig [4];
        longint a [4];
        longint nxt [4];
        longint s;
        int nz;
        orig[0] = i0; orig[1] = i1; orig[2] = i2; orig[3] = i3;
        for (int i = 0; i < 4; i++) a[i] = longint'(orig[i]);
        n = 0;
        for (int it = 1; it <= max_iter; it++) begin
            s = a[0] + a[1] + a[2] + a[3];
            nz = 0;
            for (int i = 0; i < 4; i++) begin
                nxt[i] = a[i] - ((longint'(eps) * (s - a[i])) >>> 16);
                if (nxt[i] < 0) nxt[i] = 0;
                if (nxt[i] != 0) nz++;
            end
            for (int i = 0; i < 4; i++) a[i] = nxt[i];
            n = it;
            if (nz <= 1) break;
        end
        res = 32'h0000_0000;
        for (int i = 3; i >= 0; i--) begin
            if (a[i] != 0) res = orig[i];
        end
    endfunction

    // Raise start for 'hold' sampled edges; lat = edges after the trigger edge until done.
    task automatic run_main(input int hold, output int lat);
        lat = -1;
        @(negedge clk);
        start = 1'b1;
        for (int j = 0; j < BUDGET; j++) begin
            @(negedge clk);
            if (j == hold - 1) start = 1'b0;
            if (done === 1'b1) begin
                lat = j;
                break;
            end
        end
        if (hold < 1000) start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done);
        else if (result !== 32'h0000_0000) begin end
        checks++;
        if (result !== 32'h0000_0000) $display("FAIL reset_result: got %h expected 00000000", result);
        checks++;
        if (done_aux !== 4'b0000) begin
            errors++;
            $display("FAIL reset_aux_done: got %b expected 0000", done_aux);
        end
        if (done !== 1'b0) errors++;
        if (result !== 32'h0000_0000) errors++;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got done=%b expected 0", done);
        end
    endtask

    task automatic test_default(input int hold);
        int lat;
        int en;
        logic [31:0] er;
        model(D_I0, D_I1, D_I2, D_I3, D_EPS, 64, er, en);
        repeat ($urandom_range(1, 5)) @(negedge clk);
        run_main(hold, lat);
        checks++;
        if (lat !== en + 1) begin
            errors++;
            $display("FAIL default_latency: got %0d expected %0d", lat, en + 1);
        end
        checks++;
        if (result !== er) begin
            errors++;
            $display("FAIL default_result: got %h expected %h", result, er);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b1 || result !== er) begin
                errors++;
                $display("FAIL default_hold: got done=%b result=%h expected 1 %h", done, result, er);
            end
        end
    endtask

    task automatic test_spec_default();
        int lat;
        run_main(3, lat);
        checks++;
        if (lat !== 6) begin
            errors++;
            $display("FAIL spec_latency: got %0d expected 6", lat);
        end
        checks++;
        if (result !== 32'h0000_E666) begin
            errors++;
            $display("FAIL spec_result: got %h expected 0000e666", result);
        end
    endtask

    task automatic test_hold_start();
        int lat;
        int en;
        int bad;
        logic [31:0] er;
        model(D_I0, D_I1, D_I2, D_I3, D_EPS, 64, er, en);
        run_main(1000, lat);
        checks++;
        if (lat !== en + 1) begin
            errors++;
            $display("FAIL hold_latency: got %0d expected %0d", lat, en + 1);
        end
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (done !== 1'b1 || result !== er) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_no_rerun: got %0d bad cycles expected 0", bad);
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat;
        int en;
        logic [31:0] er;
        model(D_I0, D_I1, D_I2, D_I3, D_EPS, 64, er, en);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL retrigger_drop: got done=%b expected 0", done);
        end
        lat = -1;
        for (int j = 1; j < BUDGET; j++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = j;
                break;
            end
        end
        checks++;
        if (lat !== en + 1) begin
            errors++;
            $display("FAIL retrigger_latency: got %0d expected %0d", lat, en + 1);
        end
        checks++;
        if (result !== er) begin
            errors++;
            $display("FAIL retrigger_result: got %h expected %h", result, er);
        end
    endtask

    task automatic test_reset_done();
        int bad;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (done !== 1'b0 || result !== 32'h0000_0000) begin
            errors++;
            $display("FAIL async_reset_done: got done=%b result=%h expected 0 00000000", done, result);
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stay_idle: got %0d cycles with done expected 0", bad);
        end
    endtask

    task automatic test_reset_midrun();
        int lat;
        int en;
        int r;
        logic [31:0] er;
        model(D_I0, D_I1, D_I2, D_I3, D_EPS, 64, er, en);
        r = $urandom_range(2, en);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (r - 1) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (done !== 1'b0 || result !== 32'h0000_0000) begin
            errors++;
            $display("FAIL midrun_reset: got done=%b result=%h expected 0 00000000", done, result);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat ($urandom_range(3, 8)) @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL midrun_idle: got done=%b expected 0", done);
        end
        run_main($urandom_range(1, 4), lat);
        checks++;
        if (lat !== en + 1 || result !== 32'h0000_E666) begin
            errors++;
            $display("FAIL midrun_rerun: got lat=%0d result=%h expected %0d 0000e666", lat, result, en + 1);
        end
    endtask

    task automatic test_params(input int hold);
        int lat [4];
        int en [4];
        logic [31:0] er [4];
        string nm [4];
        int found;
        nm[0] = "tie"; nm[1] = "single"; nm[2] = "cap"; nm[3] = "zero";
        model(ONE, ONE, ONE, ONE, D_EPS, 64, er[0], en[0]);
        model(ZERO, ZERO, TWO, ZERO, D_EPS, 64, er[1], en[1]);
        model(D_I0, D_I1, D_I2, D_I3, D_EPS, 2, er[2], en[2]);
        model(ZERO, ZERO, ZERO, ZERO, D_EPS, 64, er[3], en[3]);
        for (int u = 0; u < 4; u++) lat[u] = -1;
        @(negedge clk);
        start2 = 1'b1;
        for (int j = 0; j < BUDGET; j++) begin
            @(negedge clk);
            if (j == hold - 1) start2 = 1'b0;
            found = 0;
            for (int u = 0; u < 4; u++) begin
                if (lat[u] < 0 && done_aux[u] === 1'b1) lat[u] = j;
                if (lat[u] >= 0) found++;
            end
            if (found == 4) break;
        end
        start2 = 1'b0;
        for (int u = 0; u < 4; u++) begin
            checks++;
            if (lat[u] !== en[u] + 1) begin
                errors++;
                $display("FAIL %s_latency: got %0d expected %0d", nm[u], lat[u], en[u] + 1);
            end
            checks++;
            if (res_aux[u] !== er[u]) begin
                errors++;
                $display("FAIL %s_result: got %h expected %h", nm[u], res_aux[u], er[u]);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        test_reset();
        test_spec_default();
        for (int t = 0; t < 3; t++) test_default($urandom_range(1, 4));
        test_hold_start();
        test_back_to_back();
        test_reset_done();
        test_reset_midrun();
        test_params($urandom_range(1, 3));
        test_params($urandom_range(1, 3));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
